mem_line_aligner: RTL and testbench

- Parametrised line-memory access aligner between the MEM stage and a byte-enabled line RAM (one line = LINE_BYTES bytes).
- Converts scalar or vector load/store requests at any byte address into one or two line-aligned RAM beats.
- Generalises the previous aligner in three ways:
  - Line width and scalar sizes are parameters.
  - Scalar accesses may also cross a line boundary.
  - RAM read latency is a parameter, and requests use a valid/ready handshake with an explicit response strobe.

---
 rtl/mem_line_aligner.sv | 211 +++++++++++++++++++++
 tb/tb_mem_line_aligner.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_line_aligner.sv
// Line-RAM access aligner: turns scalar/vector loads and stores at any byte
// address into one or two line-aligned beats on a byte-enabled line RAM.
module mem_line_aligner #(
    parameter int LINE_BYTES  = 32,
    parameter int ADDR_W      = 32,
    parameter int LINE_ADDR_W = 14,
    parameter int SC_WR_BYTES = 2,
    parameter int SC_RD_BYTES = 4,
    parameter int RD_LAT      = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_write,
    input  logic                     req_vector,
    input  logic [ADDR_W-1:0]        req_addr,
    input  logic [SC_WR_BYTES*8-1:0] req_wdata_s,
    input  logic [LINE_BYTES*8-1:0]  req_wdata_v,
    output logic                     resp_valid,
    output logic [SC_RD_BYTES*8-1:0] resp_rdata_s,
    output logic [LINE_BYTES*8-1:0]  resp_rdata_v,
    output logic                     busy,
    output logic                     mem_rden,
    output logic                     mem_wren,
    output logic [LINE_ADDR_W-1:0]   mem_addr,
    output logic [LINE_BYTES-1:0]    mem_byteena,
    output logic [LINE_BYTES*8-1:0]  mem_wdata,
    input  logic [LINE_BYTES*8-1:0]  mem_rdata
);

    localparam int OFF_W = $clog2(LINE_BYTES);
    localparam int LW    = LINE_BYTES * 8;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_BEAT0  = 3'd1;
    localparam logic [2:0] S_BEAT1  = 3'd2;
    localparam logic [2:0] S_RDWAIT = 3'd3;
    localparam logic [2:0] S_RESP   = 3'd4;

    localparam logic [LINE_BYTES-1:0] MASK_V  = {LINE_BYTES{1'b1}};
    localparam logic [LINE_BYTES-1:0] MASK_WR = {LINE_BYTES{1'b1}} >> (LINE_BYTES - SC_WR_BYTES);
    localparam logic [LINE_BYTES-1:0] MASK_RD = {LINE_BYTES{1'b1}} >> (LINE_BYTES - SC_RD_BYTES);
    localparam logic [OFF_W+1:0]      N_V     = (OFF_W+2)'(LINE_BYTES);
    localparam logic [OFF_W+1:0]      N_WR    = (OFF_W+2)'(SC_WR_BYTES);
    localparam logic [OFF_W+1:0]      N_RD    = (OFF_W+2)'(SC_RD_BYTES);

    logic [2:0]             r_state;
    logic                   r_write;
    logic                   r_vector;
    logic                   r_split;
    logic [OFF_W-1:0]       r_off;
    logic [LINE_BYTES-1:0]  r_mask;
    logic [LW-1:0]          r_wdata;
    logic [LINE_ADDR_W-1:0] r_mem_addr;
    logic [1:0]             r_cnt;
    logic [RD_LAT-1:0]      r_rdv;
    logic [RD_LAT-1:0]      r_rdb;
    logic [LW-1:0]          r_h0;
    logic [LW-1:0]          r_h1;
    logic [SC_RD_BYTES*8-1:0] r_resp_s;
    logic [LW-1:0]          r_resp_v;

    logic [2:0]             w_state_nxt;
    logic                   w_accept;
    logic [OFF_W-1:0]       w_off_in;
    logic [LINE_ADDR_W-1:0] w_line_in;
    logic [OFF_W+1:0]       w_n_in;
    logic [LINE_BYTES-1:0]  w_mask_in;
    logic                   w_split_in;
    logic [LW-1:0]          w_wdata_in;
    logic [2*LW-1:0]        w_wide_d;
    logic [2*LINE_BYTES-1:0] w_wide_be;
    logic                   w_cap;
    logic [LW-1:0]          w_h0_nxt;
    logic [LW-1:0]          w_h1_nxt;
    logic [2*LW-1:0]        w_rd_wide;
    logic                   w_unused;

    assign req_ready  = reset && (r_state == S_IDLE);
    assign busy       = (r_state != S_IDLE);
    assign resp_valid = (r_state == S_RESP);
    assign w_accept   = req_valid && req_ready;

    assign w_off_in   = req_addr[OFF_W-1:0];
    assign w_line_in  = req_addr[OFF_W+LINE_ADDR_W-1:OFF_W];
    assign w_n_in     = req_vector ? N_V : (req_write ? N_WR : N_RD);
    assign w_mask_in  = req_vector ? MASK_V : (req_write ? MASK_WR : MASK_RD);
    assign w_split_in = ({2'b00, w_off_in} + w_n_in) > N_V;

    always_comb begin
        w_wdata_in = '0;
        if (req_vector) begin
            w_wdata_in = req_wdata_v;
        end else begin
            w_wdata_in[SC_WR_BYTES*8-1:0] = req_wdata_s;
        end
    end

    // Shifting into a double-width window yields beat 0 in the low half and
    // the spill-over for beat 1 in the high half.
    assign w_wide_d  = {{LW{1'b0}}, r_wdata} << {r_off, 3'b000};
    assign w_wide_be = {{LINE_BYTES{1'b0}}, r_mask} << r_off;

    always_comb begin
        mem_rden    = 1'b0;
        mem_wren    = 1'b0;
        mem_byteena = '0;
        mem_wdata   = '0;
        if (r_state == S_BEAT0) begin
            mem_rden    = !r_write;
            mem_wren    = r_write;
            mem_byteena = w_wide_be[LINE_BYTES-1:0];
            mem_wdata   = w_wide_d[LW-1:0];
        end else if (r_state == S_BEAT1) begin
            mem_rden    = !r_write;
            mem_wren    = r_write;
            mem_byteena = w_wide_be[2*LINE_BYTES-1:LINE_BYTES];
            mem_wdata   = w_wide_d[2*LW-1:LW];
        end
    end

    assign mem_addr     = r_mem_addr;
    assign resp_rdata_s = r_resp_s;
    assign resp_rdata_v = r_resp_v;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_accept) w_state_nxt = S_BEAT0;
            S_BEAT0:  begin
                if (r_split) w_state_nxt = S_BEAT1;
                else         w_state_nxt = r_write ? S_RESP : S_RDWAIT;
            end
            S_BEAT1:  w_state_nxt = r_write ? S_RESP : S_RDWAIT;
            S_RDWAIT: if (r_cnt == 2'd0) w_state_nxt = S_RESP;
            S_RESP:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Read data arrives RD_LAT cycles after its rden; the tag says which beat.
    assign w_cap     = r_rdv[RD_LAT-1];
    assign w_h0_nxt  = (w_cap && !r_rdb[RD_LAT-1]) ? mem_rdata : r_h0;
    assign w_h1_nxt  = (w_cap &&  r_rdb[RD_LAT-1]) ? mem_rdata : r_h1;
    assign w_rd_wide = {w_h1_nxt, w_h0_nxt} >> {r_off, 3'b000};

    assign w_unused  = ^{req_addr[ADDR_W-1:OFF_W+LINE_ADDR_W], w_rd_wide[2*LW-1:LW]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_write    <= 1'b0;
            r_vector   <= 1'b0;
            r_split    <= 1'b0;
            r_off      <= '0;
            r_mask     <= '0;
            r_wdata    <= '0;
            r_mem_addr <= '0;
            r_cnt      <= '0;
            r_rdv      <= '0;
            r_rdb      <= '0;
            r_h0       <= '0;
            r_h1       <= '0;
            r_resp_s   <= '0;
            r_resp_v   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_write    <= req_write;
                r_vector   <= req_vector;
                r_split    <= w_split_in;
                r_off      <= w_off_in;
                r_mask     <= w_mask_in;
                r_wdata    <= w_wdata_in;
                r_mem_addr <= w_line_in;
            end else if (r_state == S_BEAT0 && r_split) begin
                r_mem_addr <= r_mem_addr + LINE_ADDR_W'(1);
            end

            if (w_state_nxt == S_RDWAIT && r_state != S_RDWAIT) begin
                r_cnt <= 2'(RD_LAT - 1);
            end else if (r_state == S_RDWAIT && r_cnt != 2'd0) begin
                r_cnt <= r_cnt - 2'd1;
            end

            r_rdv[0] <= mem_rden;
            r_rdb[0] <= (r_state == S_BEAT1);
            for (int i = 1; i < RD_LAT; i++) begin
                r_rdv[i] <= r_rdv[i-1];
                r_rdb[i] <= r_rdb[i-1];
            end
            r_h0 <= w_h0_nxt;
            r_h1 <= w_h1_nxt;

            if (w_state_nxt == S_RESP && r_state != S_RESP) begin
                if (r_write) begin
                    r_resp_s <= '0;
                    r_resp_v <= '0;
                end else if (r_vector) begin
                    r_resp_s <= '0;
                    r_resp_v <= w_rd_wide[LW-1:0];
                end else begin
                    r_resp_s <= w_rd_wide[SC_RD_BYTES*8-1:0];
                    r_resp_v <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_line_aligner.sv
// Directed bench for mem_line_aligner: table of requests with hand-computed
// beats, latencies and results, against a small byte-enabled line RAM model.
module tb_mem_line_aligner;

    localparam int LB  = 32;
    localparam int LW  = 256;
    localparam int LAW = 14;
    localparam int RDL = 2;

    logic           clk;
    logic           reset;
    logic           req_valid;
    logic           req_ready;
    logic           req_write;
    logic           req_vector;
    logic [31:0]    req_addr;
    logic [15:0]    req_wdata_s;
    logic [LW-1:0]  req_wdata_v;
    logic           resp_valid;
    logic [31:0]    resp_rdata_s;
    logic [LW-1:0]  resp_rdata_v;
    logic           busy;
    logic           mem_rden;
    logic           mem_wren;
    logic [LAW-1:0] mem_addr;
    logic [LB-1:0]  mem_byteena;
    logic [LW-1:0]  mem_wdata;
    logic [LW-1:0]  mem_rdata;

    int errors = 0;
    int checks = 0;

    mem_line_aligner #(
        .LINE_BYTES(LB), .ADDR_W(32), .LINE_ADDR_W(LAW),
        .SC_WR_BYTES(2), .SC_RD_BYTES(4), .RD_LAT(RDL)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_vector(req_vector), .req_addr(req_addr),
        .req_wdata_s(req_wdata_s), .req_wdata_v(req_wdata_v),
        .resp_valid(resp_valid), .resp_rdata_s(resp_rdata_s), .resp_rdata_v(resp_rdata_v),
        .busy(busy), .mem_rden(mem_rden), .mem_wren(mem_wren), .mem_addr(mem_addr),
        .mem_byteena(mem_byteena), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Line RAM model: 16 lines indexed by mem_addr[3:0]; line k byte j starts as k*32+j.
    logic [LW-1:0] ram [16];
    logic [LW-1:0] rd_pipe [RDL];
    logic          ram_load;

    always @(posedge clk) begin
        if (ram_load) begin
            for (int k = 0; k < 16; k++)
                for (int j = 0; j < LB; j++)
                    ram[k][j*8 +: 8] <= 8'(k*32 + j);
        end else if (mem_wren) begin
            for (int b = 0; b < LB; b++)
                if (mem_byteena[b]) ram[mem_addr[3:0]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
        end
        rd_pipe[0] <= mem_rden ? ram[mem_addr[3:0]] : {8{32'hDEADBEEF}};
        for (int i = 1; i < RDL; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_rdata = rd_pipe[RDL-1];

    typedef struct {
        logic           wr;
        logic           vec;
        logic [31:0]    addr;
        logic [15:0]    ws;
        logic [LW-1:0]  wv;
        int             lat;
        int             nb;
        logic [LAW-1:0] a0;
        logic [LAW-1:0] a1;
        logic [LB-1:0]  be0;
        logic [LB-1:0]  be1;
        logic [LW-1:0]  wd0;
        logic [LW-1:0]  wd1;
        logic [31:0]    rs;
        logic [LW-1:0]  rv;
    } vec_t;

    function automatic vec_t st(input logic vec, input logic [31:0] addr, input logic [15:0] ws,
                                input logic [LW-1:0] wv, input int lat, input int nb,
                                input logic [LAW-1:0] a0, input logic [LAW-1:0] a1,
                                input logic [LB-1:0] be0, input logic [LB-1:0] be1,
                                input logic [LW-1:0] wd0, input logic [LW-1:0] wd1);
        vec_t v;
        v.wr = 1'b1; v.vec = vec; v.addr = addr; v.ws = ws; v.wv = wv;
        v.lat = lat; v.nb = nb; v.a0 = a0; v.a1 = a1;
        v.be0 = be0; v.be1 = be1; v.wd0 = wd0; v.wd1 = wd1;
        v.rs = '0; v.rv = '0;
        return v;
    endfunction

    function automatic vec_t ld(input logic vec, input logic [31:0] addr, input int lat, input int nb,
                                input logic [LAW-1:0] a0, input logic [LAW-1:0] a1,
                                input logic [31:0] rs, input logic [LW-1:0] rv);
        vec_t v;
        v.wr = 1'b0; v.vec = vec; v.addr = addr; v.ws = '0; v.wv = '0;
        v.lat = lat; v.nb = nb; v.a0 = a0; v.a1 = a1;
        v.be0 = '0; v.be1 = '0; v.wd0 = '0; v.wd1 = '0;
        v.rs = rs; v.rv = rv;
        return v;
    endfunction

    task automatic chk(input string tag, input string what, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s: got %0h expected %0h", tag, what, act, exp);
        end
    endtask

    task automatic garbage();
        req_write   = 1'($urandom);
        req_vector  = 1'($urandom);
        req_addr    = $urandom;
        req_wdata_s = 16'($urandom);
        req_wdata_v = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endtask

    // Entered at posedge+1 of an IDLE cycle; returns at posedge+1 of the IDLE cycle after RESP.
    task automatic run_vec(input vec_t v, input string tag);
        logic [LAW-1:0] ga0, ga1;
        logic [LB-1:0]  gb0, gb1;
        logic [LW-1:0]  gw0, gw1, rv;
        logic [31:0]    rs;
        logic           busbad, dirbad;
        int             nb, lat;
        ga0 = '0; ga1 = '0; gb0 = '0; gb1 = '0; gw0 = '0; gw1 = '0;
        rv = '0; rs = '0; busbad = 1'b0; dirbad = 1'b0; nb = 0; lat = 0;
        chk(tag, "ready", LW'(req_ready), LW'(1));
        req_valid = 1'b1; req_write = v.wr; req_vector = v.vec; req_addr = v.addr;
        req_wdata_s = v.ws; req_wdata_v = v.wv;
        @(posedge clk); #1;
        chk(tag, "busy", LW'({busy, req_ready}), LW'(2'b10));
        for (int k = 1; k <= 12; k++) begin
            if (k > 1) begin @(posedge clk); #1; end
            garbage();
            if (mem_rden || mem_wren) begin
                if (mem_wren !== v.wr || mem_rden !== !v.wr) dirbad = 1'b1;
                if (nb == 0) begin ga0 = mem_addr; gb0 = mem_byteena; gw0 = mem_wdata; end
                else if (nb == 1) begin ga1 = mem_addr; gb1 = mem_byteena; gw1 = mem_wdata; end
                nb++;
            end else if (mem_byteena !== '0 || mem_wdata !== '0) begin
                busbad = 1'b1;
            end
            if (resp_valid === 1'b1) begin
                lat = k; rs = resp_rdata_s; rv = resp_rdata_v;
                break;
            end
        end
        req_valid = 1'b0;
        chk(tag, "latency", LW'(lat), LW'(v.lat));
        chk(tag, "nbeats", LW'(nb), LW'(v.nb));
        chk(tag, "rw_dir", LW'(dirbad), LW'(0));
        chk(tag, "idle_bus", LW'(busbad), LW'(0));
        chk(tag, "addr0", LW'(ga0), LW'(v.a0));
        if (v.wr) begin
            chk(tag, "be0", LW'(gb0), LW'(v.be0));
            chk(tag, "wd0", gw0, v.wd0);
        end
        if (v.nb == 2) begin
            chk(tag, "addr1", LW'(ga1), LW'(v.a1));
            if (v.wr) begin
                chk(tag, "be1", LW'(gb1), LW'(v.be1));
                chk(tag, "wd1", gw1, v.wd1);
            end
        end
        chk(tag, "rdata_s", LW'(rs), LW'(v.rs));
        chk(tag, "rdata_v", rv, v.rv);
        @(posedge clk); #1;
        chk(tag, "after_resp", LW'({resp_valid, busy, req_ready}), LW'(3'b001));
    endtask

    vec_t tbl [12];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [LW-1:0] ramp0, rampa, line1;
        logic          stale;
        ramp0 = 256'h1f1e1d1c1b1a191817161514131211100f0e0d0c0b0a09080706050403020100;
        rampa = 256'hbfbebdbcbbbab9b8b7b6b5b4b3b2b1b0afaeadacabaaa9a8a7a6a5a4a3a2a1a0;
        line1 = 256'h11223d3c3b3a393837363534333231302f2e2d2c2b2a292827262524232221be;

        tbl[0]  = st(1'b1, 32'h40, 16'h0, ramp0, 2, 1, 14'd2, 14'd0, 32'hFFFFFFFF, 32'h0, ramp0, '0);
        tbl[1]  = ld(1'b1, 32'h50, 5, 2, 14'd2, 14'd3, 32'h0,
                     256'h6f6e6d6c6b6a696867666564636261601f1e1d1c1b1a19181716151413121110);
        tbl[2]  = st(1'b0, 32'h3E, 16'h1122, '0, 2, 1, 14'd1, 14'd0, 32'hC0000000, 32'h0,
                     {16'h1122, 240'h0}, '0);
        tbl[3]  = st(1'b0, 32'h40, 16'h3344, '0, 2, 1, 14'd2, 14'd0, 32'h00000003, 32'h0,
                     256'h3344, '0);
        tbl[4]  = ld(1'b0, 32'h3E, 5, 2, 14'd1, 14'd2, 32'h33441122, '0);
        tbl[5]  = ld(1'b0, 32'hABC00044, 4, 1, 14'd2, 14'd0, 32'h07060504, '0);
        tbl[6]  = st(1'b0, 32'h1F, 16'hBEEF, '0, 3, 2, 14'd0, 14'd1, 32'h80000000, 32'h00000001,
                     {8'hEF, 248'h0}, 256'hBE);
        tbl[7]  = ld(1'b0, 32'h1E, 5, 2, 14'd0, 14'd1, 32'h21BEEF1E, '0);
        tbl[8]  = ld(1'b0, 32'h7FFFE, 5, 2, 14'h3FFF, 14'd0, 32'h0100FFFE, '0);
        tbl[9]  = st(1'b1, 32'h68, 16'h0, rampa, 3, 2, 14'd3, 14'd4, 32'hFFFFFF00, 32'h000000FF,
                     256'hb7b6b5b4b3b2b1b0afaeadacabaaa9a8a7a6a5a4a3a2a1a00000000000000000,
                     256'hbfbebdbcbbbab9b8);
        tbl[10] = ld(1'b1, 32'h68, 5, 2, 14'd3, 14'd4, 32'h0, rampa);
        tbl[11] = ld(1'b1, 32'h20, 4, 1, 14'd1, 14'd0, 32'h0, line1);

        reset = 1'b0; ram_load = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_vector = 1'b0; req_addr = '0;
        req_wdata_s = '0; req_wdata_v = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst", "ctl", LW'({resp_valid, busy, mem_rden, mem_wren}), LW'(0));
        chk("rst", "mem_addr", LW'(mem_addr), LW'(0));
        chk("rst", "rdata_s", LW'(resp_rdata_s), LW'(0));
        chk("rst", "rdata_v", resp_rdata_v, '0);
        ram_load = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("rst", "released", LW'({req_ready, busy}), LW'(2'b10));

        for (int i = 0; i < 12; i++) run_vec(tbl[i], $sformatf("v%0d", i));

        // Reset arriving in BEAT1 of a split load must wipe everything at once.
        run_vec(tbl[7], "pre_rst");
        req_valid = 1'b1; req_write = 1'b0; req_vector = 1'b0; req_addr = 32'h3E;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        chk("midrst", "in_beat1", LW'({mem_rden, mem_addr}), LW'({1'b1, 14'd2}));
        reset = 1'b0;
        req_valid = 1'b1; req_vector = 1'b1; req_addr = 32'h40;
        #1;
        chk("midrst", "ctl", LW'({resp_valid, busy, mem_rden, mem_wren}), LW'(0));
        chk("midrst", "byteena", LW'(mem_byteena), LW'(0));
        chk("midrst", "wdata", mem_wdata, '0);
        chk("midrst", "mem_addr", LW'(mem_addr), LW'(0));
        chk("midrst", "rdata_s", LW'(resp_rdata_s), LW'(0));
        chk("midrst", "rdata_v", resp_rdata_v, '0);
        repeat (3) @(posedge clk);
        #1;
        chk("midrst", "no_accept", LW'({busy, mem_rden}), LW'(0));
        req_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("midrst", "released", LW'({req_ready, busy, resp_valid}), LW'(3'b100));
        stale = 1'b0;
        repeat (6) begin
            if (resp_valid || mem_rden || mem_wren) stale = 1'b1;
            @(posedge clk); #1;
        end
        chk("midrst", "no_stale", LW'(stale), LW'(0));
        run_vec(tbl[11], "post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
